data_mem_responder: RTL
=======================

# data_mem_responder

Multi-cycle data-memory responder: the target end of the pipeline's load/store port. It accepts one word read or write request at a time from an initiator, such as a stalling MEM stage or a cache-miss engine. It models a fixed access latency with a counter-driven FSM and returns the result with a one-cycle acknowledge. It replaces the zero-latency data memory when the pipeline is run against realistic memory timing.

## Interface
- DEPTH, 256: number of 32-bit words in the storage array; a power of two, minimum 4.
- LATENCY, 3: wait cycles between request acceptance and the response cycle; minimum 1.
- clk_i  input  1  clock; all state changes on its rising edge.
- rst_i  input  1  reset, asynchronous, active-low.
- req_i  input  1  request valid; sampled only while ready_o=1.
- we_i  input  1  1 = store word, 0 = load word; qualified by req_i.
- addr_i  input  32  byte address; word index = addr_i[log2(DEPTH)+1:2].
- data_i  input  32  store data; qualified by req_i & we_i.
- ready_o  output  1  responder idle and able to accept a request.
- ack_o  output  1  one-cycle response strobe; read data and err_o are valid with it.
- data_o  output  32  load result; held between loads.
- err_o  output  1  the acknowledged request was misaligned or out of range.

## Operation
- FSM states:
  - IDLE: ready_o=1.
  - WAIT: ready_o=0; counter cnt is active.
  - RESP: ready_o=0, ack_o=1.
- IDLE, req_i=1 at an edge: latch we_i, addr_i and data_i into internal registers; cnt <= LATENCY-1; next state WAIT.
- WAIT, cnt != 0: cnt <= cnt-1.
- WAIT, cnt == 0, at that edge:
  - Perform the access using the latched request.
  - Store: write mem[idx].
  - Load: data_o <= mem[idx].
  - Set err_o and go to RESP.
- RESP: unconditional return to IDLE at the next edge. A req_i seen in RESP is ignored.
- Error condition: addr[1:0] != 0, or addr[31:2] >= DEPTH.
  - No memory write occurs.
  - A load returns data_o=0.
  - err_o=1 for the RESP cycle.
- err_o updates only on the WAIT→RESP edge and holds until the next one.
- The initiator must hold req_i, we_i, addr_i and data_i until it samples ready_o=1 at an edge. The responder never back-pressures mid-transaction.
- A store does not modify data_o.
- The storage array is not reset; its contents are undefined until written. Testbenches may preload it by hierarchical access.
- cnt width is clog2(LATENCY)+1 bits; it never wraps, because it only decrements from LATENCY-1 to 0.

## Timing
- Reset (rst_i=0, immediate and asynchronous):
  - state=IDLE, cnt=0.
  - ready_o=1, ack_o=0, data_o=0, err_o=0.
- Reset mid-transaction (WAIT or RESP): the transaction is aborted and no write occurs. If reset is asserted in the same cycle as the WAIT→RESP edge, reset wins.
- Request accepted at edge N:
  - WAIT occupies cycles N+1 .. N+LATENCY.
  - The access happens at edge N+LATENCY.
  - ack_o=1 in the cycle after edge N+LATENCY.
  - ready_o returns to 1 after edge N+LATENCY+1.
- Earliest next acceptance is edge N+LATENCY+2, giving throughput of one transaction per LATENCY+2 cycles.
- ready_o and ack_o are decoded directly from state registers: no combinational path from any input.
- A read after a write to the same address, accepted later, returns the new data. There is no bypass hazard, because requests never overlap.

## Test plan
- Store then load, LATENCY=3: store addr=0x10, data=0xDEADBEEF accepted at edge 0 → ack_o=1 in cycle 4 (after edge 3), err_o=0. A load of 0x10 accepted at edge 5 → ack_o after edge 8 with data_o=0xDEADBEEF; data_o still 0xDEADBEEF 10 cycles later.
- Request held through busy: req_i held high continuously with alternating addresses → exactly one ack per 5 cycles. ready_o is low from the accept edge through the ack cycle. Each ack corresponds to the operands present at its accept edge.
- Misaligned store: addr=0x13 → ack with err_o=1. A following load of 0x10 still returns the previous value and err_o=0.
- Out of range, DEPTH=256: load addr=0x400 → ack with err_o=1, data_o=0. Store to 0x400 → ack with err_o=1 and mem[0] unchanged.
- Reset mid-operation: store 0x20 ← 0x12345678, with rst_i pulsed low for 1 cycle during WAIT. Outputs are at reset values immediately, no ack follows, and a later load of 0x20 returns the pre-reset contents.
- LATENCY=1 instance: load accepted at edge 0 → ack_o in the cycle after edge 1 and ready_o high after edge 2.

Source files
------------

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder: accepts one word load/store at a time,
// waits a fixed LATENCY, then acknowledges for exactly one cycle.
module data_mem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic        ready_o,
    output logic        ack_o,
    output logic [31:0] data_o,
    output logic        err_o
);

    localparam int              AW       = $clog2(DEPTH);
    localparam int              CW       = $clog2(LATENCY) + 1;
    localparam logic [CW-1:0]   CNT_LOAD = CW'(LATENCY - 1);
    localparam logic [29:0]     DEPTH_W  = 30'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_next_state;
    logic [CW-1:0]  r_cnt;
    logic [CW-1:0]  w_next_cnt;

    logic           r_we;
    logic [31:0]    r_addr;
    logic [31:0]    r_wdata;
    logic [31:0]    r_rdata;
    logic           r_err;
    logic [31:0]    r_mem [DEPTH];

    logic           w_capture;
    logic           w_access;
    logic           w_err;
    logic           w_mem_we;
    logic [AW-1:0]  w_idx;

    // Access decode works on the latched request, never on the live inputs.
    assign w_idx    = r_addr[AW+1:2];
    assign w_err    = (r_addr[1:0] != 2'b00) || (r_addr[31:2] >= DEPTH_W);
    assign w_mem_we = w_access && r_we && !w_err;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_capture    = 1'b0;
        w_access     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_i) begin
                    w_capture    = 1'b1;
                    w_next_cnt   = CNT_LOAD;
                    w_next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == '0) begin
                    w_access     = 1'b1;
                    w_next_state = S_RESP;
                end else begin
                    w_next_cnt = r_cnt - CW'(1);
                end
            end
            S_RESP: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_capture) begin
            r_we    <= we_i;
            r_addr  <= addr_i;
            r_wdata <= data_i;
        end
    end

    // Load data and error flag change only on the WAIT->RESP edge; stores leave data_o alone.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (w_access) begin
            r_err <= w_err;
            if (!r_we) begin
                r_rdata <= w_err ? 32'd0 : r_mem[w_idx];
            end
        end
    end

    // NOTE: the storage array has no reset; an async reset forces IDLE, which already blocks the write.
    always_ff @(posedge clk_i) begin
        if (w_mem_we) begin
            r_mem[w_idx] <= r_wdata;
        end
    end

    assign ready_o = (r_state == S_IDLE);
    assign ack_o   = (r_state == S_RESP);
    assign data_o  = r_rdata;
    assign err_o   = r_err;

endmodule
